// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types, defaults and counter-width helper for the perceptron core
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int MAC_LAT_DEF = 3;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequences one pipelined MAC through an N_INPUTS dot product with threshold fire
module mac_seq_ctrl
    import perceptron_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int N_INPUTS = 4,
    parameter int MAC_LAT  = MAC_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    output logic [DATA_W-1:0] mac_x,
    output logic [DATA_W-1:0] mac_w,
    output logic [DATA_W-1:0] mac_prev,
    input  logic [DATA_W-1:0] mac_out,
    input  logic [DATA_W-1:0] threshold,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result,
    output logic              fire
);

    localparam int ECW = cnt_w(N_INPUTS);
    localparam int WCW = cnt_w(MAC_LAT);
    localparam logic [ECW-1:0] LAST_ELEM = ECW'(N_INPUTS - 1);
    localparam logic [WCW-1:0] CAPTURE   = WCW'(MAC_LAT);

    state_t         state;
    logic [ECW-1:0] elem_cnt;
    logic [WCW-1:0] wait_cnt;

    // Sequencer FSM; every output is a register updated on the state transition that changes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            in_ready     <= 1'b0;
            mac_x        <= '0;
            mac_w        <= '0;
            mac_prev     <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            fire         <= 1'b0;
            elem_cnt     <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mac_prev <= '0;
                        elem_cnt <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        mac_x    <= in_x;
                        mac_w    <= in_w;
                        wait_cnt <= '0;
                        in_ready <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == CAPTURE) begin
                        // Operands have been stable for the full MAC latency: mac_out is this element's sum.
                        mac_prev <= mac_out;
                        if (elem_cnt == LAST_ELEM) begin
                            result       <= mac_out;
                            fire         <= ($signed(mac_out) >= $signed(threshold));
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                            in_ready <= 1'b1;
                            state    <= LOAD;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // result and fire stay as the last completed product after hand-off.
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
